// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster pipeline.
//   - Default 640x480 @ 60 Hz timing values (visible, porches, sync, totals).
//   - coord_t: the 10-bit screen coordinate type used by the timing generator
//     and by every downstream sprite/tile renderer.
//   - coord_fits(): true when a total count can be represented in coord_t.
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int COORD_W = 10;

   typedef logic [COORD_W-1:0] coord_t;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   // A counter of modulus 'total' runs 0..total-1, so the largest value it
   // holds must be representable in COORD_W bits.
   function automatic bit coord_fits(input int total);
      return (total >= 1) && ((total - 1) < (1 << COORD_W));
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo counter used for the horizontal and vertical raster positions.
//   clk        in   clock
//   reset      in   synchronous active-high reset, loads RESET_VALUE
//   inc        in   advance the count by one this cycle
//   count      out  current registered count, 0..MODULUS-1
//   count_next out  value count will take on the next edge (when not in reset)
//   wrap       out  count is at MODULUS-1 and inc is high
// -----------------------------------------------------------------------------
module wrap_counter
   import vga_pkg::*;
#(
   parameter int MODULUS     = DEF_H_TOTAL,
   parameter int RESET_VALUE = MODULUS - 1
)
(
   input  logic   clk,
   input  logic   reset,
   input  logic   inc,
   output coord_t count,
   output coord_t count_next,
   output logic   wrap
);

   localparam coord_t LAST  = coord_t'(MODULUS - 1);
   localparam coord_t START = coord_t'(RESET_VALUE);

   // The next value is exposed so the parent can decode its outputs one
   // cycle early and register them alongside the count.
   always_comb begin
      wrap       = inc && (count == LAST);
      count_next = count;
      if (wrap) begin
         count_next = '0;
      end else if (inc) begin
         count_next = count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= START;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running raster timing generator for the VGA pipeline.
//   vga_clk      in   pixel clock
//   reset        in   synchronous active-high reset; parks at the last pixel
//   DrawX        out  horizontal position, 0..H_TOTAL-1
//   DrawY        out  vertical position, 0..V_TOTAL-1
//   blank        out  1 on visible pixels
//   hs / vs      out  sync pulses, HS_ACTIVE / VS_ACTIVE during sync
//   line_start   out  one-cycle pulse at DrawX==0
//   frame_start  out  one-cycle pulse at DrawX==0, DrawY==0
//   frame_count  out  frames started since reset, wraps at 2^16
// All outputs are registers and describe the same pixel as DrawX/DrawY.
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE = DEF_H_VISIBLE,
   parameter int   H_FRONT   = DEF_H_FRONT,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BACK    = DEF_H_BACK,
   parameter int   V_VISIBLE = DEF_V_VISIBLE,
   parameter int   V_FRONT   = DEF_V_FRONT,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BACK    = DEF_V_BACK,
   parameter logic HS_ACTIVE = 1'b0,
   parameter logic VS_ACTIVE = 1'b0
)
(
   input  logic        vga_clk,
   input  logic        reset,
   output coord_t      DrawX,
   output coord_t      DrawY,
   output logic        blank,
   output logic        hs,
   output logic        vs,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
   localparam coord_t HS_FIRST  = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_LAST   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam coord_t VS_FIRST  = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_LAST   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   // Totals that overflow coord_t would silently alias; stop elaboration.
   if (!coord_fits(H_TOTAL)) begin : g_h_total_check
      $error("vga_timing_gen: H_TOTAL-1 does not fit in coord_t");
   end
   if (!coord_fits(V_TOTAL)) begin : g_v_total_check
      $error("vga_timing_gen: V_TOTAL-1 does not fit in coord_t");
   end

   coord_t h_next;
   coord_t v_next;
   logic   h_wrap;
   logic   v_wrap;
   logic   blank_next;
   logic   hs_next;
   logic   vs_next;

   // Horizontal counter runs every cycle; the vertical counter advances on
   // the horizontal wrap so both roll over to (0,0) on the same edge.
   wrap_counter #(
      .MODULUS     (H_TOTAL),
      .RESET_VALUE (H_TOTAL - 1)
   ) u_h_counter (
      .clk        (vga_clk),
      .reset      (reset),
      .inc        (1'b1),
      .count      (DrawX),
      .count_next (h_next),
      .wrap       (h_wrap)
   );

   wrap_counter #(
      .MODULUS     (V_TOTAL),
      .RESET_VALUE (V_TOTAL - 1)
   ) u_v_counter (
      .clk        (vga_clk),
      .reset      (reset),
      .inc        (h_wrap),
      .count      (DrawY),
      .count_next (v_next),
      .wrap       (v_wrap)
   );

   // Decode from the next-state position so the registered flags line up
   // with the registered DrawX/DrawY with zero skew.
   always_comb begin
      blank_next = (h_next < H_VIS_END) && (v_next < V_VIS_END);
      hs_next    = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? HS_ACTIVE : ~HS_ACTIVE;
      vs_next    = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? VS_ACTIVE : ~VS_ACTIVE;
   end

   // h_wrap means the next pixel is x=0 (a new line); v_wrap additionally
   // means the next line is y=0, i.e. a new frame.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         blank       <= 1'b0;
         hs          <= ~HS_ACTIVE;
         vs          <= ~VS_ACTIVE;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         blank       <= blank_next;
         hs          <= hs_next;
         vs          <= vs_next;
         line_start  <= h_wrap;
         frame_start <= v_wrap;
         if (v_wrap) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule
